// File: rtl/smpl_queue_pkg.sv
// smpl_queue_pkg
// Shared definitions for the stereo sample queue: buffer geometry, the
// pointer and sample types, and the sequencing FSM state encoding.
// No ports (package).
package smpl_queue_pkg;

    localparam int DEPTH  = 1024;  // entries per channel
    localparam int WIN    = 1021;  // samples streamed per readout window
    localparam int PTR_W  = 10;    // pointer width, wraps 1023 -> 0
    localparam int SMPL_W = 16;    // sample width

    typedef logic [PTR_W-1:0]         ptr_t;
    typedef logic signed [SMPL_W-1:0] smpl_t;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        IDLE  = 2'd1,
        PRIME = 2'd2,
        SEQ   = 2'd3
    } state_t;

    // Terminal value for both the fill counter and the sequence counter.
    localparam ptr_t WIN_LAST = ptr_t'(WIN - 1);

endpackage

// File: rtl/smpl_queue_dualPort1024x16.sv
// dualPort1024x16
// 1024 x 16 simple dual-port RAM: one synchronous write port and one
// synchronous read port with a single cycle of read latency. Contents are
// not reset.
// Ports:
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write address (10 bits)
//   wdata  in   write data (16 bits)
//   raddr  in   read address (10 bits)
//   rdata  out  read data, registered: mem[raddr] of the previous cycle
module dualPort1024x16
    import smpl_queue_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  logic [SMPL_W-1:0] wdata,
    input  logic [PTR_W-1:0]  raddr,
    output logic [SMPL_W-1:0] rdata
);

    logic [SMPL_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/smpl_queue.sv
// smpl_queue
// Circular stereo sample buffer feeding a downstream FIR. Every accepted
// write (after the initial fill of WIN samples) triggers one readout window
// of the WIN most recent samples, oldest first, newest last.
//
// Handshake: wrt_smpl is a one-cycle strobe qualifying lft_smpl/rght_smpl.
// There is no ready; a strobe arriving while a window is being primed or
// streamed is dropped. sequencing is the valid for lft_out/rght_out and is
// high for exactly WIN consecutive cycles per window.
//
// Optional feature: define SMPL_QUEUE_OVF_EN to add the sticky ovf output,
// set when a strobe is dropped and cleared only by reset.
//
// Ports:
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   lft_smpl    in   left sample to store (signed 16)
//   rght_smpl   in   right sample to store (signed 16)
//   wrt_smpl    in   write strobe
//   lft_out     out  left sample read out, valid while sequencing
//   rght_out    out  right sample read out, valid while sequencing
//   sequencing  out  readout window active
//   ovf         out  sticky dropped-write flag (SMPL_QUEUE_OVF_EN only)
module smpl_queue
    import smpl_queue_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [SMPL_W-1:0] lft_smpl,
    input  logic signed [SMPL_W-1:0] rght_smpl,
    input  logic                     wrt_smpl,
    output logic signed [SMPL_W-1:0] lft_out,
    output logic signed [SMPL_W-1:0] rght_out,
    output logic                     sequencing
`ifdef SMPL_QUEUE_OVF_EN
    ,
    output logic                     ovf
`endif
);

    state_t state;
    state_t state_nxt;

    ptr_t new_ptr;    // next slot to write
    ptr_t old_ptr;    // oldest slot of the current window
    ptr_t rd_ptr;     // read address used while streaming
    ptr_t fill_cnt;   // accepted writes since reset, only used in FILL
    ptr_t seq_cnt;    // index of the current SEQ cycle within the window

    logic ram_we;
    logic wr_drop;
    ptr_t ram_raddr;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            FILL:  if (wrt_smpl && (fill_cnt == WIN_LAST)) state_nxt = PRIME;
            IDLE:  if (wrt_smpl) state_nxt = PRIME;
            PRIME: state_nxt = SEQ;
            SEQ:   if (seq_cnt == WIN_LAST) state_nxt = IDLE;
            default: state_nxt = FILL;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        sequencing = (state == SEQ);
        ram_we     = wrt_smpl && ((state == FILL) || (state == IDLE));
        wr_drop    = wrt_smpl && ((state == PRIME) || (state == SEQ));
        // PRIME presents old_ptr so its data is registered by the RAM in
        // time for the first SEQ cycle; SEQ then runs one address ahead.
        ram_raddr  = (state == PRIME) ? old_ptr : rd_ptr;
    end

    // ------------------------------------------------------------------
    // Pointers and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            new_ptr  <= '0;
            old_ptr  <= '0;
            rd_ptr   <= '0;
            fill_cnt <= '0;
            seq_cnt  <= '0;
        end else begin
            if (ram_we) begin
                new_ptr <= new_ptr + ptr_t'(1);
            end
            if ((state == FILL) && wrt_smpl) begin
                fill_cnt <= fill_cnt + ptr_t'(1);
            end
            // Once full, each new sample pushes the oldest one out.
            if ((state == IDLE) && wrt_smpl) begin
                old_ptr <= old_ptr + ptr_t'(1);
            end
            if (state == PRIME) begin
                rd_ptr  <= old_ptr + ptr_t'(1);
                seq_cnt <= '0;
            end else if (state == SEQ) begin
                rd_ptr  <= rd_ptr + ptr_t'(1);
                seq_cnt <= seq_cnt + ptr_t'(1);
            end
        end
    end

`ifdef SMPL_QUEUE_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (wr_drop) begin
            ovf <= 1'b1;
        end
    end
`else
    // Dropped strobes are simply ignored in this build.
    logic unused_drop;
    assign unused_drop = wr_drop;
`endif

    // ------------------------------------------------------------------
    // Storage, one RAM per channel
    // ------------------------------------------------------------------
    dualPort1024x16 u_ram_lft (
        .clk   (clk),
        .we    (ram_we),
        .waddr (new_ptr),
        .wdata (lft_smpl),
        .raddr (ram_raddr),
        .rdata (lft_out)
    );

    dualPort1024x16 u_ram_rght (
        .clk   (clk),
        .we    (ram_we),
        .waddr (new_ptr),
        .wdata (rght_smpl),
        .raddr (ram_raddr),
        .rdata (rght_out)
    );

endmodule

// File: tb/tb_smpl_queue.sv
// tb_smpl_queue
// Self-checking bench for smpl_queue. Inputs change on the falling edge,
// outputs are sampled on the falling edge.
module tb_smpl_queue;

    localparam int WIN = 1021;

    typedef struct {
        logic        wrt;
        logic [15:0] lft;
        logic [15:0] rght;
        logic        exp_seq;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] lft_smpl;
    logic [15:0] rght_smpl;
    logic        wrt_smpl;
    logic [15:0] lft_out;
    logic [15:0] rght_out;
    logic        sequencing;
`ifdef SMPL_QUEUE_OVF_EN
    logic        ovf;
`endif

    int total;
    int bad;

    vec_t        vec [1100];
    int          n_vec;
    logic [15:0] exp_q [$];

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    smpl_queue dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .lft_smpl   (lft_smpl),
        .rght_smpl  (rght_smpl),
        .wrt_smpl   (wrt_smpl),
        .lft_out    (lft_out),
        .rght_out   (rght_out),
        .sequencing (sequencing)
`ifdef SMPL_QUEUE_OVF_EN
        ,
        .ovf        (ovf)
`endif
    );

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    function automatic logic [15:0] neg16(input int v);
        logic [15:0] r;
        r = 16'(0 - v);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Fill table: a few idle cycles, then 1020 writes of base..base+1019.
    // The window must not start during any of them.
    task automatic build_fill_table(input int base);
        n_vec = 0;
        for (int i = 0; i < 4; i++) begin
            vec[n_vec] = '{wrt: 1'b0, lft: 16'h0, rght: 16'h0, exp_seq: 1'b0};
            n_vec++;
        end
        for (int i = 0; i < WIN - 1; i++) begin
            vec[n_vec] = '{wrt: 1'b1, lft: 16'(base + i), rght: neg16(base + i), exp_seq: 1'b0};
            n_vec++;
        end
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < n_vec; i++) begin
            @(negedge clk);
            check($sformatf("%s_seq[%0d]", tag, i), 32'(sequencing), 32'(vec[i].exp_seq));
            wrt_smpl  = vec[i].wrt;
            lft_smpl  = vec[i].lft;
            rght_smpl = vec[i].rght;
        end
    endtask

    // Single-cycle strobe; returns at the falling edge of cycle T+1.
    task automatic write_smpl(input int v);
        @(negedge clk);
        wrt_smpl  = 1'b1;
        lft_smpl  = 16'(v);
        rght_smpl = neg16(v);
        @(negedge clk);
        wrt_smpl  = 1'b0;
    endtask

    // Called right after write_smpl (cycle T+1). Checks PRIME, then WIN
    // cycles of data first..first+WIN-1, then sequencing low again.
    // strobe_k >= 0 injects a strobe during SEQ cycle strobe_k (cycle T+2+k).
    task automatic check_window(input int first, input int strobe_k, input string tag);
        int          n_bad;
        int          bad_k;
        logic [15:0] e;
        logic [15:0] bad_l;
        logic [15:0] bad_r;
        logic        bad_s;
        logic [15:0] bad_e;
        exp_q.delete();
        for (int k = 0; k < WIN; k++) exp_q.push_back(16'(first + k));
        check({tag, "_prime_seq"}, 32'(sequencing), 32'd0);
        n_bad = 0;
        bad_k = -1;
        bad_l = '0; bad_r = '0; bad_s = 1'b0; bad_e = '0;
        for (int k = 0; k < WIN; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            if (sequencing !== 1'b1 || lft_out !== e || rght_out !== (16'h0 - e)) begin
                if (n_bad == 0) begin
                    bad_k = k; bad_l = lft_out; bad_r = rght_out; bad_s = sequencing; bad_e = e;
                end
                n_bad++;
            end
            if (k == strobe_k) begin
                wrt_smpl  = 1'b1;
                lft_smpl  = 16'h7777;
                rght_smpl = 16'h7777;
            end else if (k == strobe_k + 1) begin
                wrt_smpl  = 1'b0;
            end
        end
        total++;
        if (n_bad != 0) begin
            bad++;
            $display("FAIL %s_data: %0d bad cycles, first at k=%0d seq=%b lft=%0h rght=%0h expected seq=1 lft=%0h rght=%0h",
                     tag, n_bad, bad_k, bad_s, bad_l, bad_r, bad_e, 16'(16'h0 - bad_e));
        end
        @(negedge clk);
        check({tag, "_end_seq"}, 32'(sequencing), 32'd0);
    endtask

    // ------------------------------------------------------------------
    // Test
    // ------------------------------------------------------------------
    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        wrt_smpl  = 1'b0;
        lft_smpl  = '0;
        rght_smpl = '0;
        repeat (3) @(negedge clk);
        check("reset_seq", 32'(sequencing), 32'd0);
`ifdef SMPL_QUEUE_OVF_EN
        check("reset_ovf", 32'(ovf), 32'd0);
`endif
        rst_n = 1'b1;

        // Fill with 0..1019: no window yet.
        build_fill_table(0);
        run_table("fill0");

        // 1021st write starts the first window 0..1020.
        write_smpl(1020);
        check_window(0, -1, "win0");
`ifdef SMPL_QUEUE_OVF_EN
        check("win0_ovf", 32'(ovf), 32'd0);
`endif

        // Write from IDLE with a dropped strobe at T+500 inside the window.
        write_smpl(1021);
        check_window(1, 498, "win1");
        @(negedge clk);
        check("win1_after_seq", 32'(sequencing), 32'd0);
`ifdef SMPL_QUEUE_OVF_EN
        check("win1_ovf", 32'(ovf), 32'd1);
`endif

        // Continue through the wrap of slot 1023; a stored stray strobe
        // would shift every later window.
        for (int v = 1022; v <= 1100; v++) begin
            write_smpl(v);
            check_window(v - (WIN - 1), -1, $sformatf("win_v%0d", v));
        end

        // Reset at T+300 inside a window.
        write_smpl(1101);
        check("rst_prime_seq", 32'(sequencing), 32'd0);
        repeat (299) @(negedge clk);
        check("rst_mid_seq", 32'(sequencing), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_async_drop", 32'(sequencing), 32'd0);
`ifdef SMPL_QUEUE_OVF_EN
        check("rst_ovf_clear", 32'(ovf), 32'd0);
`endif
        @(negedge clk);
        check("rst_hold_seq", 32'(sequencing), 32'd0);
        rst_n = 1'b1;

        // Refill with new data: 1020 writes keep sequencing low, the
        // 1021st starts a window over the new data from slot 0.
        build_fill_table(3000);
        run_table("fill1");
        write_smpl(3000 + WIN - 1);
        check_window(3000, -1, "win_refill");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
